scan_sequencer: RTL and testbench

//  Generates the 4-bit select and enable that drive the 4-to-16 one-hot decoder stage.

---
 rtl/scan_sequencer_pkg.sv | 14 +
 rtl/scan_dwell_timer.sv | 23 ++
 rtl/scan_sequencer.sv | 153 +++++++++++++++
 tb/tb_scan_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer and its downstream decoder stage:
// FSM state encodings and default widths.
package scan_sequencer_pkg;

  localparam int SCAN_SEL_W   = 4;
  localparam int SCAN_DWELL_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEEK  = 2'd1,
    S_DWELL = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell down-counter: loaded on entry to DWELL, counts down while enabled,
// and raises zero on the last cycle of the dwell.
module scan_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;

  assign zero = (cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving the select/enable of the one-hot decoder stage.
// Optional SCAN_PASS_COUNT_EN adds a saturating pass_count output.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int SEL_W   = SCAN_SEL_W,
  parameter int DWELL_W = SCAN_DWELL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [SEL_W-1:0]      first,
  input  logic [SEL_W-1:0]      last,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  continuous,
  input  logic [2**SEL_W-1:0]   skip_mask,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_en,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
`ifdef SCAN_PASS_COUNT_EN
  ,output logic [7:0]           pass_count
`endif
);

  scan_state_t          state, state_d;
  logic [SEL_W-1:0]     ptr, ptr_d, first_q, last_q, sel_d;
  logic [DWELL_W-1:0]   dwell_q;
  logic [2**SEL_W-1:0]  mask_q;
  logic                 cont_q;
  logic                 sel_en_d, busy_d, done_d, wrap_d;
  logic                 capture, tmr_load, tmr_en, tmr_zero, eop, step, abort;

  scan_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .val   (dwell_q),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    sel_d    = sel;
    sel_en_d = sel_en;
    busy_d   = busy;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    capture  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    eop      = 1'b0;
    step     = 1'b0;
    abort    = stop && (state != S_IDLE);
    case (state)
      S_IDLE:
        if (start && !stop) begin
          capture = 1'b1;
          ptr_d   = first;
          busy_d  = 1'b1;
          state_d = S_SEEK;
        end
      S_SEEK:
        if (!mask_q[ptr]) begin
          sel_d    = ptr;
          sel_en_d = 1'b1;
          tmr_load = 1'b1;
          state_d  = S_DWELL;
        end else if (ptr == last_q) eop = 1'b1;
        else                        step = 1'b1;
      S_DWELL: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          sel_en_d = 1'b0;
          if (ptr == last_q) eop = 1'b1;
          else begin
            step    = 1'b1;
            state_d = S_SEEK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      ptr_d  = ptr + 1'b1;
      wrap_d = (ptr == {SEL_W{1'b1}});
    end
    if (eop) begin
      done_d = 1'b1;
      if (cont_q) begin
        ptr_d   = first_q;
        state_d = S_SEEK;
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end
    // stop overrides everything in the same cycle, including a pass ending now
    if (abort) begin
      state_d  = S_IDLE;
      sel_en_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      sel    <= '0;
      sel_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      sel    <= sel_d;
      sel_en <= sel_en_d;
      busy   <= busy_d;
      done   <= done_d;
      wrap   <= wrap_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      mask_q  <= '0;
    end else if (capture) begin
      first_q <= first;
      last_q  <= last;
      dwell_q <= dwell;
      cont_q  <= continuous;
      mask_q  <= skip_mask;
    end

`ifdef SCAN_PASS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                             pass_count <= '0;
    else if (capture)                       pass_count <= '0;
    else if (done_d && pass_count != 8'hFF) pass_count <= pass_count + 1'b1;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; expected per-cycle traces are hand-derived.
// Build with SCAN_PASS_COUNT_EN to also check pass_count.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, continuous;
  logic [3:0]  first, last, sel;
  logic [7:0]  dwell;
  logic [15:0] skip_mask;
  logic        sel_en, busy, done, wrap;
`ifdef SCAN_PASS_COUNT_EN
  logic [7:0]  pass_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .first      (first),
    .last       (last),
    .dwell      (dwell),
    .continuous (continuous),
    .skip_mask  (skip_mask),
    .sel        (sel),
    .sel_en     (sel_en),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
`ifdef SCAN_PASS_COUNT_EN
    ,.pass_count (pass_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [3:0] f, input logic [3:0] l, input logic [7:0] d,
                    input logic c, input logic [15:0] m);
    first = f; last = l; dwell = d; continuous = c; skip_mask = m;
    stop = 1'b0; start = 1'b1;
  endtask

  // Cycle i (1..n) after the next edge is compared against nibble/bit [n-i],
  // so the literals read left to right in time order. Value: {sel,sel_en,done,busy,wrap}.
  task automatic seq(input string tag, input int n, input logic [63:0] sels,
                     input logic [15:0] en, input logic [15:0] dn,
                     input logic [15:0] bz, input logic [15:0] wr);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      chk($sformatf("%s.c%0d", tag, i), {24'h0, sel, sel_en, done, busy, wrap},
          {24'h0, sels[4*(n-i) +: 4], en[n-i], dn[n-i], bz[n-i], wr[n-i]});
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    first = '0; last = '0; dwell = '0; skip_mask = '0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", {24'h0, sel, sel_en, done, busy, wrap}, 32'h0);
`ifdef SCAN_PASS_COUNT_EN
    chk("reset_pc", {24'h0, pass_count}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2..4, dwell 1: two-cycle enables, one-cycle gaps
    go(4'd2, 4'd4, 8'd1, 1'b0, 16'h0000);
    seq("t1", 11, 64'h02223334444, 16'b01101101100, 16'b00000000010,
        16'b11111111100, 16'b0);
`ifdef SCAN_PASS_COUNT_EN
    chk("t1_pc", {24'h0, pass_count}, 32'd1);
`endif

    // 14..1 wraps through 15->0
    go(4'd14, 4'd1, 8'd0, 1'b0, 16'h0000);
    seq("t2", 10, 64'h4EEFF00111, 16'b0101010100, 16'b0000000010,
        16'b1111111100, 16'b0000100000);

    // channel 3 masked: 2-cycle gap between 2 and 4
    go(4'd2, 4'd4, 8'd1, 1'b0, 16'h0008);
    seq("t3", 9, 64'h122224444, 16'b011001100, 16'b000000010,
        16'b111111100, 16'b0);

    // whole range masked: no enable, done 3 cycles after SEEK entry
    go(4'd0, 4'd2, 8'd1, 1'b0, 16'h0007);
    seq("t4", 5, 64'h44444, 16'b00000, 16'b00010, 16'b11100, 16'b0);

    // continuous 5..6, dwell 3: two full passes then stop mid-dwell
    go(4'd5, 4'd6, 8'd3, 1'b1, 16'h0000);
    seq("t5a", 11, 64'h45555566666, 16'b01111011110, 16'b00000000001,
        16'b11111111111, 16'b0);
    seq("t5b", 10, 64'h5555566666, 16'b1111011110, 16'b0000000001,
        16'b1111111111, 16'b0);
    seq("t5c", 2, 64'h55, 16'b11, 16'b00, 16'b11, 16'b0);
    stop = 1'b1;
    seq("t5d", 3, 64'h555, 16'b000, 16'b000, 16'b000, 16'b0);
`ifdef SCAN_PASS_COUNT_EN
    chk("t5_pc", {24'h0, pass_count}, 32'd2);
`endif

    // start and stop together: stop wins
    go(4'd1, 4'd1, 8'd0, 1'b0, 16'h0000);
    stop = 1'b1;
    seq("t_ss", 2, 64'h55, 16'b00, 16'b00, 16'b00, 16'b0);

    // async reset mid-dwell, then a fresh single-channel scan
    go(4'd2, 4'd4, 8'd5, 1'b0, 16'h0000);
    seq("t6a", 3, 64'h522, 16'b011, 16'b000, 16'b111, 16'b0);
    #3 rst_n = 1'b0;
    #1 chk("t6_async", {24'h0, sel, sel_en, done, busy, wrap}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    go(4'd7, 4'd7, 8'd0, 1'b0, 16'h0000);
    seq("t6b", 4, 64'h0777, 16'b0100, 16'b0010, 16'b1100, 16'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
